// File: rtl/bkm_pkg.sv
// Shared encodings for the BKM iteration controller: FSM state codes and BKM mode values.
package bkm_pkg;

    localparam logic [2:0] BKM_SEQ_IDLE  = 3'd0;
    localparam logic [2:0] BKM_SEQ_LOAD  = 3'd1;
    localparam logic [2:0] BKM_SEQ_ITER  = 3'd2;
    localparam logic [2:0] BKM_SEQ_DRAIN = 3'd3;
    localparam logic [2:0] BKM_SEQ_DONE  = 3'd4;

    localparam logic BKM_MODE_E = 1'b0;
    localparam logic BKM_MODE_L = 1'b1;

    typedef enum logic [2:0] {
        SEQ_IDLE  = BKM_SEQ_IDLE,
        SEQ_LOAD  = BKM_SEQ_LOAD,
        SEQ_ITER  = BKM_SEQ_ITER,
        SEQ_DRAIN = BKM_SEQ_DRAIN,
        SEQ_DONE  = BKM_SEQ_DONE
    } bkm_seq_state_e;

endpackage

// File: rtl/bkm_lat_timer.sv
// Loadable down-counter that paces step strobes and the pipeline drain.
// Saturates at zero; 'one' lets the sequencer prepare the next step index a cycle early.
module bkm_lat_timer #(
    parameter int WL = 3
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          srst,
    input  logic          enable,
    input  logic          load,
    input  logic [WL-1:0] load_val,
    output logic          zero,
    output logic          one
);

    logic [WL-1:0] cnt_q;
    logic [WL-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_q <= '0;
        end else if (srst) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == WL'(1));

endmodule

// File: rtl/bkm_step_sequencer.sv
// Schedules N_STEPS iterations of one shared bkm_step datapath per accepted operation,
// spacing strobes STEP_LAT cycles apart and presenting the result after the pipeline drains.
module bkm_step_sequencer
    import bkm_pkg::*;
#(
    parameter int N_STEPS  = 64,
    parameter int WN       = 7,
    parameter int STEP_LAT = 1,
    parameter int WL       = 3
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          srst,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    output logic          mode_q,
    output logic          step_en,
    output logic [WN-1:0] step_n,
    output logic          sel_init,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [WL-1:0] RELOAD     = WL'(STEP_LAT - 1);
    // The drain covers the STEP_LAT-1 cycles after the last strobe, so it starts one lower.
    localparam logic [WL-1:0] DRAIN_LOAD = (STEP_LAT > 1) ? WL'(STEP_LAT - 2) : '0;
    localparam logic [WN-1:0] LAST_STEP  = WN'(N_STEPS - 1);
    localparam bit            SINGLE     = (STEP_LAT == 1);

    bkm_seq_state_e state_q, state_d;
    logic [WN-1:0]  step_n_q, step_n_d;
    logic           mode_d;
    logic           tmr_load;
    logic [WL-1:0]  tmr_val;
    logic           tmr_zero;
    logic           tmr_one;

    bkm_lat_timer #(
        .WL (WL)
    ) u_lat_timer (
        .clk      (clk),
        .arst     (arst),
        .srst     (srst),
        .enable   (enable),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

    // step_n_q advances on the edge entering a strobe cycle so it always shows the issued index.
    always_comb begin
        state_d  = state_q;
        step_n_d = step_n_q;
        mode_d   = mode_q;
        tmr_load = 1'b0;
        tmr_val  = RELOAD;
        case (state_q)
            SEQ_IDLE: begin
                if (in_valid) begin
                    state_d  = SEQ_LOAD;
                    step_n_d = '0;
                    mode_d   = (mode == BKM_MODE_L) ? BKM_MODE_L : BKM_MODE_E;
                end
            end
            SEQ_LOAD: begin
                tmr_load = 1'b1;
                state_d  = SEQ_ITER;
                if (SINGLE) begin
                    step_n_d = step_n_q + 1'b1;
                end
            end
            SEQ_ITER: begin
                if (tmr_zero) begin
                    if (step_n_q == LAST_STEP) begin
                        if (SINGLE) begin
                            state_d = SEQ_DONE;
                        end else begin
                            state_d  = SEQ_DRAIN;
                            tmr_load = 1'b1;
                            tmr_val  = DRAIN_LOAD;
                        end
                    end else begin
                        tmr_load = 1'b1;
                        if (SINGLE) begin
                            step_n_d = step_n_q + 1'b1;
                        end
                    end
                end else if (tmr_one) begin
                    step_n_d = step_n_q + 1'b1;
                end
            end
            SEQ_DRAIN: begin
                if (tmr_zero) begin
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                if (out_ready) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q  <= SEQ_IDLE;
            step_n_q <= '0;
            mode_q   <= BKM_MODE_E;
        end else if (srst) begin
            state_q  <= SEQ_IDLE;
            step_n_q <= '0;
            mode_q   <= BKM_MODE_E;
        end else if (enable) begin
            state_q  <= state_d;
            step_n_q <= step_n_d;
            mode_q   <= mode_d;
        end
    end

    assign in_ready  = enable & (state_q == SEQ_IDLE);
    assign step_en   = enable & ((state_q == SEQ_LOAD) | ((state_q == SEQ_ITER) & tmr_zero));
    assign step_n    = step_n_q;
    assign sel_init  = (state_q == SEQ_LOAD);
    assign busy      = (state_q != SEQ_IDLE);
    assign out_valid = enable & (state_q == SEQ_DONE);

endmodule

// File: tb/tb_bkm_step_sequencer.sv
// Two sequencer instances (default and STEP_LAT=3/N_STEPS=4) checked every cycle against a
// phase-based model: strobe k at phase 1+k*L, result at phase 1+N*L, phase frozen while disabled.
module tb_bkm_step_sequencer;
    import bkm_pkg::*;

    localparam int N0 = 64;
    localparam int L0 = 1;
    localparam int N1 = 4;
    localparam int L1 = 3;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic srst = 1'b0;
    logic enable = 1'b1;
    logic in_valid = 1'b0;
    logic mode = 1'b0;
    logic out_ready = 1'b1;

    logic       in_ready [2];
    logic       mode_qo  [2];
    logic       step_en  [2];
    logic       sel_init [2];
    logic       busy     [2];
    logic       out_valid[2];
    logic [6:0] step_n0;
    logic [2:0] step_n1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit m_act [2];
    int m_p   [2];
    bit m_mode[2];
    int m_last[2];
    int n_of  [2] = '{N0, N1};
    int l_of  [2] = '{L0, L1};

    int strb  [2];
    int ov_cyc[2];
    int acc;

    bkm_step_sequencer #(.N_STEPS(N0), .WN(7), .STEP_LAT(L0), .WL(3)) u_dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready[0]), .mode(mode), .mode_q(mode_qo[0]),
        .step_en(step_en[0]), .step_n(step_n0), .sel_init(sel_init[0]), .busy(busy[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready)
    );

    bkm_step_sequencer #(.N_STEPS(N1), .WN(3), .STEP_LAT(L1), .WL(2)) u_dut3 (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready[1]), .mode(mode), .mode_q(mode_qo[1]),
        .step_en(step_en[1]), .step_n(step_n1), .sel_init(sel_init[1]), .busy(busy[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_act[i]  = 1'b0;
        m_p[i]    = 0;
        m_mode[i] = 1'b0;
        m_last[i] = 0;
    endtask

    task automatic compare_dut(input int i);
        int n, l, p;
        logic e_ir, e_se, e_si, e_bz, e_ov;
        logic [31:0] e_sn, g_sn;
        n = n_of[i];
        l = l_of[i];
        p = m_p[i];
        e_ir = 1'b0; e_se = 1'b0; e_si = 1'b0; e_bz = 1'b0; e_ov = 1'b0;
        e_sn = 32'(m_last[i]);
        if (!m_act[i]) begin
            e_ir = enable;
        end else begin
            e_bz = 1'b1;
            e_sn = ((p - 1) / l > n - 1) ? 32'(n - 1) : 32'((p - 1) / l);
            if (p <= 1 + (n - 1) * l && (p - 1) % l == 0) begin
                e_se = enable;
                e_si = (p == 1);
            end
            if (p == 1 + n * l) e_ov = enable;
        end
        g_sn = (i == 0) ? 32'(step_n0) : 32'(step_n1);
        check($sformatf("d%0d_in_ready", i),  32'(in_ready[i]),  32'(e_ir));
        check($sformatf("d%0d_step_en", i),   32'(step_en[i]),   32'(e_se));
        check($sformatf("d%0d_sel_init", i),  32'(sel_init[i]),  32'(e_si));
        check($sformatf("d%0d_busy", i),      32'(busy[i]),      32'(e_bz));
        check($sformatf("d%0d_out_valid", i), 32'(out_valid[i]), 32'(e_ov));
        check($sformatf("d%0d_mode_q", i),    32'(mode_qo[i]),   32'(m_mode[i]));
        check($sformatf("d%0d_step_n", i),    g_sn,              e_sn);
    endtask

    task automatic advance(input int i);
        if (!arst || srst) begin
            model_reset(i);
        end else if (enable) begin
            if (!m_act[i]) begin
                if (in_valid) begin
                    m_act[i]  = 1'b1;
                    m_p[i]    = 1;
                    m_mode[i] = mode;
                end
            end else if (m_p[i] == 1 + n_of[i] * l_of[i]) begin
                if (out_ready) begin
                    m_act[i]  = 1'b0;
                    m_last[i] = n_of[i] - 1;
                end
            end else begin
                m_p[i]++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!arst) model_reset(i);
            compare_dut(i);
            if (step_en[i]) strb[i]++;
            if (out_valid[i] && ov_cyc[i] < 0) ov_cyc[i] = cyc;
            advance(i);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_op(input logic md);
        int n = 0;
        while (!(in_ready[0] && in_ready[1]) && n < 300) begin
            tick(1);
            n++;
        end
        if (!(in_ready[0] && in_ready[1])) check("wait_idle", 0, 1);
        strb[0] = 0; strb[1] = 0;
        ov_cyc[0] = -1; ov_cyc[1] = -1;
        in_valid = 1'b1;
        mode = md;
        tick(1);
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input int budget);
        int n = 0;
        while (ov_cyc[0] < 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (ov_cyc[0] < 0) check("wait_out_valid", 0, 1);
    endtask

    task automatic wait_strobe(input int k, input int budget);
        bit found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            #1;
            if (step_en[0] && step_n0 == 7'(k)) found = 1'b1;
        end
        if (!found) check("wait_strobe", 0, 1);
    endtask

    initial begin
        strb[0] = 0; strb[1] = 0;
        ov_cyc[0] = -1; ov_cyc[1] = -1;
        tick(3);
        arst = 1'b1;
        tick(2);

        // Plain operation: latency and strobe count on both instances
        start_op(1'b0);
        wait_ov(200);
        tick(2);
        check("lat_default", 32'(ov_cyc[0] - acc + 1), 32'd65);
        check("lat_l3n4",    32'(ov_cyc[1] - acc + 1), 32'd13);
        check("strobes_default", 32'(strb[0]), 32'd64);
        check("strobes_l3n4",    32'(strb[1]), 32'd4);

        // Consumer stalls for 20 cycles after the result appears
        out_ready = 1'b0;
        start_op(1'b1);
        wait_ov(200);
        tick(20);
        check("stall_strobes", 32'(strb[0]), 32'd64);
        check("stall_out_valid", 32'(out_valid[0]), 32'd1);
        out_ready = 1'b1;
        tick(2);

        // Enable gap of 5 cycles after strobe 10
        start_op(1'b0);
        wait_strobe(10, 100);
        tick(1);
        enable = 1'b0;
        tick(5);
        enable = 1'b1;
        wait_ov(200);
        tick(2);
        check("lat_gap_default", 32'(ov_cyc[0] - acc + 1), 32'd70);
        check("lat_gap_l3n4",    32'(ov_cyc[1] - acc + 1), 32'd18);
        check("gap_strobes", 32'(strb[0]), 32'd64);

        // Asynchronous reset in the cycle of strobe 30
        start_op(1'b1);
        wait_strobe(30, 100);
        arst = 1'b0;
        #1;
        check("arst_busy",    32'(busy[0]),    32'd0);
        check("arst_step_en", 32'(step_en[0]), 32'd0);
        check("arst_step_n",  32'(step_n0),    32'd0);
        check("arst_mode_q",  32'(mode_qo[0]), 32'd0);
        tick(2);
        arst = 1'b1;
        tick(80);
        check("arst_no_result", 32'(ov_cyc[0]), 32'hFFFF_FFFF);
        start_op(1'b0);
        wait_ov(200);
        tick(2);
        check("post_arst_lat", 32'(ov_cyc[0] - acc + 1), 32'd65);
        check("post_arst_strobes", 32'(strb[0]), 32'd64);

        // mode=1 at accept then toggling, in_valid held high throughout
        strb[0] = 0; ov_cyc[0] = -1;
        mode = 1'b1;
        in_valid = 1'b1;
        tick(1);
        for (int n = 0; n < 200 && ov_cyc[0] < 0; n++) begin
            mode = 1'($urandom);
            tick(1);
        end
        check("hold_mode_q", 32'(mode_qo[0]), 32'd1);
        check("hold_strobes", 32'(strb[0]), 32'd64);
        in_valid = 1'b0;
        tick(140);

        // Synchronous reset mid-operation
        start_op(1'b1);
        tick(5 + int'($urandom_range(0, 50)));
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        tick(3);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 4) == 0;
            mode      = 1'($urandom);
            out_ready = ($urandom % 3) != 0;
            enable    = ($urandom % 8) != 0;
            srst      = ($urandom % 250) == 0;
            arst      = ($urandom % 600) != 0;
            tick(1);
        end
        arst = 1'b1;
        srst = 1'b0;
        enable = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
